// File: rtl/loop_sequencer_pkg.sv
// Shared definitions for the loop sequencer: default counter width and FSM state encodings.
package loop_sequencer_pkg;

    localparam int LEN_COUNTER_DATA = 8;

    typedef enum logic [1:0] {
        SEQ_IDLE = 2'd0,
        SEQ_RUN  = 2'd1,
        SEQ_DONE = 2'd2
    } seq_state_e;

endpackage

// File: rtl/loop_sequencer_index_stage.sv
// One wrap-around index counter of the nested loop; wrap flags the increment that returns it to 0.
module index_stage #(
    parameter int WORD_LENGTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr,
    input  logic                   inc,
    input  logic [WORD_LENGTH-1:0] max,
    output logic [WORD_LENGTH-1:0] idx,
    output logic                   wrap
);

    localparam logic [WORD_LENGTH-1:0] ONE_C  = {{(WORD_LENGTH-1){1'b0}}, 1'b1};
    localparam logic [WORD_LENGTH-1:0] ZERO_C = {WORD_LENGTH{1'b0}};

    logic [WORD_LENGTH-1:0] idx_r;
    logic                   wrap_s;

    assign wrap_s = inc & (idx_r == (max - ONE_C));
    assign wrap   = wrap_s;
    assign idx    = idx_r;

    // Index register: clear has priority over the wrap/increment step.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_r <= ZERO_C;
        end else if (clr) begin
            idx_r <= ZERO_C;
        end else if (wrap_s) begin
            idx_r <= ZERO_C;
        end else if (inc) begin
            idx_r <= idx_r + ONE_C;
        end else begin
            idx_r <= idx_r;
        end
    end

endmodule

// File: rtl/loop_sequencer.sv
// Two-level (row, col) sweep generator with valid/ready backpressure and a done/err pulse at the end.
module loop_sequencer
    import loop_sequencer_pkg::*;
#(
    parameter int WORD_LENGTH = LEN_COUNTER_DATA
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [WORD_LENGTH-1:0] row_max,
    input  logic [WORD_LENGTH-1:0] col_max,
    input  logic                   out_ready,
    output logic                   out_valid,
    output logic [WORD_LENGTH-1:0] row,
    output logic [WORD_LENGTH-1:0] col,
    output logic                   last,
    output logic                   busy,
    output logic                   done,
    output logic                   err
);

    localparam logic [WORD_LENGTH-1:0] ONE_C  = {{(WORD_LENGTH-1){1'b0}}, 1'b1};
    localparam logic [WORD_LENGTH-1:0] ZERO_C = {WORD_LENGTH{1'b0}};

    seq_state_e             state_r;
    seq_state_e             next_state_s;
    logic [WORD_LENGTH-1:0] row_lat_r;
    logic [WORD_LENGTH-1:0] col_lat_r;
    logic                   load_s;
    logic                   zero_start_s;
    logic                   valid_s;
    logic                   hs_s;
    logic                   last_s;
    logic                   clr_s;
    logic                   col_wrap_s;
    logic                   row_wrap_s;
    logic                   row_inc_s;
    logic [WORD_LENGTH-1:0] row_s;
    logic [WORD_LENGTH-1:0] col_s;
    logic                   busy_r;
    logic                   done_r;
    logic                   err_r;

    assign valid_s   = (state_r == SEQ_RUN);
    assign hs_s      = valid_s & out_ready;
    assign last_s    = valid_s & (row_s == (row_lat_r - ONE_C)) & (col_s == (col_lat_r - ONE_C));
    // On the final beat both stages wrap together, so DONE already sees (0,0).
    assign clr_s     = load_s | (state_r == SEQ_DONE);
    assign row_inc_s = hs_s & col_wrap_s;

    index_stage #(.WORD_LENGTH(WORD_LENGTH)) u_col (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr_s),
        .inc  (hs_s),
        .max  (col_lat_r),
        .idx  (col_s),
        .wrap (col_wrap_s)
    );

    index_stage #(.WORD_LENGTH(WORD_LENGTH)) u_row (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr_s),
        .inc  (row_inc_s),
        .max  (row_lat_r),
        .idx  (row_s),
        .wrap (row_wrap_s)
    );

    // Next-state decode; zero-sized requests skip RUN and report through err.
    always_comb begin
        next_state_s = state_r;
        load_s       = 1'b0;
        zero_start_s = 1'b0;
        case (state_r)
            SEQ_IDLE: begin
                if (start) begin
                    if ((row_max == ZERO_C) || (col_max == ZERO_C)) begin
                        next_state_s = SEQ_DONE;
                        zero_start_s = 1'b1;
                    end else begin
                        next_state_s = SEQ_RUN;
                        load_s       = 1'b1;
                    end
                end else begin
                    next_state_s = SEQ_IDLE;
                end
            end
            SEQ_RUN: begin
                if (hs_s && last_s) begin
                    next_state_s = SEQ_DONE;
                end else begin
                    next_state_s = SEQ_RUN;
                end
            end
            SEQ_DONE: begin
                next_state_s = SEQ_IDLE;
            end
            default: begin
                next_state_s = SEQ_IDLE;
            end
        endcase
    end

    // State, latched sizes and the registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= SEQ_IDLE;
            row_lat_r <= ZERO_C;
            col_lat_r <= ZERO_C;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            state_r <= next_state_s;
            if (load_s) begin
                row_lat_r <= row_max;
                col_lat_r <= col_max;
            end else begin
                row_lat_r <= row_lat_r;
                col_lat_r <= col_lat_r;
            end
            busy_r <= (next_state_s != SEQ_IDLE);
            done_r <= (next_state_s == SEQ_DONE);
            err_r  <= zero_start_s;
        end
    end

    assign out_valid = valid_s;
    assign row       = row_s;
    assign col       = col_s;
    assign last      = last_s;
    assign busy      = busy_r;
    assign done      = done_r;
    assign err       = err_r;

endmodule

// File: tb/tb_loop_sequencer.sv
// Directed self-checking bench for loop_sequencer with a 4-bit counter width.
module tb_loop_sequencer;

    localparam int W = 4;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] row_max;
    logic [W-1:0] col_max;
    logic         out_ready;
    logic         out_valid;
    logic [W-1:0] row;
    logic [W-1:0] col;
    logic         last;
    logic         busy;
    logic         done;
    logic         err;

    int total = 0;
    int bad   = 0;

    loop_sequencer #(.WORD_LENGTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .row_max   (row_max),
        .col_max   (col_max),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .row       (row),
        .col       (col),
        .last      (last),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_busy"},  {31'd0, busy},      32'd0);
        chk({tag, "_done"},  {31'd0, done},      32'd0);
        chk({tag, "_err"},   {31'd0, err},       32'd0);
        chk({tag, "_last"},  {31'd0, last},      32'd0);
        chk({tag, "_row"},   {28'd0, row},       32'd0);
        chk({tag, "_col"},   {28'd0, col},       32'd0);
    endtask

    // mode 0: ready always high; 1: ready pattern 1,0,0; 2: ready high and start/size poked mid-sweep
    task automatic sweep(input int rows, input int cols, input int mode);
        int er;
        int ec;
        int cyc;
        int beats;
        bit fin;
        row_max   = rows[W-1:0];
        col_max   = cols[W-1:0];
        start     = 1'b1;
        out_ready = 1'b0;
        tick();
        start = 1'b0;
        er = 0; ec = 0; cyc = 0; beats = 0; fin = 1'b0;
        while (!fin && cyc < 2000) begin
            out_ready = (mode == 1) ? ((cyc % 3) == 0) : 1'b1;
            if (mode == 2) begin
                start   = 1'b1;
                row_max = 4'd7;
                col_max = 4'd1;
            end
            chk("beat_valid", {31'd0, out_valid}, 32'd1);
            chk("beat_busy",  {31'd0, busy},      32'd1);
            chk("beat_done",  {31'd0, done},      32'd0);
            chk("beat_row",   {28'd0, row},       er);
            chk("beat_col",   {28'd0, col},       ec);
            chk("beat_last",  {31'd0, last},      ((er == rows - 1) && (ec == cols - 1)) ? 32'd1 : 32'd0);
            if (out_ready) begin
                beats++;
                if ((er == rows - 1) && (ec == cols - 1)) begin
                    fin = 1'b1;
                end else if (ec == cols - 1) begin
                    ec = 0;
                    er++;
                end else begin
                    ec++;
                end
            end
            tick();
            cyc++;
        end
        chk("sweep_finished", {31'd0, fin}, 32'd1);
        chk("sweep_beats", beats, rows * cols);
        if (mode == 0) begin
            chk("run_cycles", cyc, rows * cols);
        end
        chk("done_pulse",  {31'd0, done},      32'd1);
        chk("done_err",    {31'd0, err},       32'd0);
        chk("done_busy",   {31'd0, busy},      32'd1);
        chk("done_valid",  {31'd0, out_valid}, 32'd0);
        chk("done_last",   {31'd0, last},      32'd0);
        tick();
        start = 1'b0;
        chk_idle("after_done");
        tick();
        chk_idle("still_idle");
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        row_max   = 4'd0;
        col_max   = 4'd0;
        out_ready = 1'b0;
        tick();
        tick();
        chk_idle("reset");
        rst = 1'b0;
        tick();
        chk_idle("post_reset");

        // 2x3 at full rate, then with stalls, then with start/size poked during RUN and DONE
        sweep(2, 3, 0);
        sweep(2, 3, 1);
        sweep(2, 3, 2);

        // zero-size request: done and err together one cycle after start, no beats
        row_max = 4'd0;
        col_max = 4'd5;
        start   = 1'b1;
        tick();
        start = 1'b0;
        chk("zero_valid", {31'd0, out_valid}, 32'd0);
        chk("zero_done",  {31'd0, done},      32'd1);
        chk("zero_err",   {31'd0, err},       32'd1);
        chk("zero_busy",  {31'd0, busy},      32'd1);
        tick();
        chk_idle("zero_idle");

        // reset after the third beat of a 4x4 sweep aborts it without a done pulse
        row_max   = 4'd4;
        col_max   = 4'd4;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        tick();
        chk("abort_row_pre", {28'd0, row}, 32'd0);
        chk("abort_col_pre", {28'd0, col}, 32'd3);
        rst = 1'b1;
        tick();
        chk_idle("abort_reset");
        rst       = 1'b0;
        out_ready = 1'b0;
        tick();
        chk_idle("abort_no_done");
        sweep(4, 4, 0);

        // largest sweep for W=4
        sweep(15, 15, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/loop_sequencer.md
# loop_sequencer

- Two-level nested loop sequencer: walks (row, col) index pairs over a row_max × col_max space and issues one pair per accepted beat on a valid/ready output.
- Sits directly downstream of the control unit's start/size registers and feeds the datapath's wrap-around counters and address logic.
- Completion is reported with a single-cycle done pulse.
- Replaces ad-hoc enable/overflow chaining of flat counters with proper backpressure.

## Interface
Parameters:
- WORD_LENGTH, default `LEN_COUNTER_DATA, width of sizes and indices.

Ports (reset is synchronous and active-high, single clock domain):
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request to begin a sweep; honoured only in IDLE.
- row_max  input  WORD_LENGTH  number of rows; sampled when start is accepted.
- col_max  input  WORD_LENGTH  number of columns; sampled when start is accepted.
- out_ready  input  1  downstream accepts the current beat.
- out_valid  output  1  row/col hold a valid beat.
- row  output  WORD_LENGTH  current row index.
- col  output  WORD_LENGTH  current column index.
- last  output  1  current beat is the final pair of the sweep.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse at end of sweep.
- err  output  1  one-cycle pulse, coincident with done, when a zero-sized sweep is started.

## Operation
- **States:** IDLE, RUN, DONE.
- **IDLE:**
  - out_valid=0, busy=0, row=col=0.
  - start with row_max≠0 and col_max≠0: latch both sizes, clear indices, go to RUN.
  - start with either size 0: go to DONE with err set; no beats are issued.
- **RUN:**
  - out_valid=1; row/col are the current pair.
  - Handshake: a beat transfers on out_valid & out_ready.
  - Without a handshake, row, col and last hold stable.
- **Index advance on handshake:**
  - If col == col_lat−1: col←0 and row←row+1.
  - Otherwise col←col+1.
- **Last beat:**
  - last = out_valid & (row == row_lat−1) & (col == col_lat−1), combinational from state.
  - Handshake on the last beat: go to DONE. Indices are not incremented past the final pair.
- **DONE:**
  - out_valid=0, busy=1, done=1 (err=1 if entered from a zero-size start).
  - Unconditionally go to IDLE next cycle. Indices clear to 0.
- **start outside IDLE:** ignored, including in DONE. Live changes to row_max/col_max during RUN have no effect.
- **Arithmetic:**
  - Comparisons use WORD_LENGTH-bit latched sizes minus 1; no overflow is possible since sizes ≥1.
  - Max sweep is (2^W−1)² beats.
  - No internal beat counter is needed.
- **Reset (any state, including mid-sweep):** next edge forces IDLE, latched sizes 0, row=col=0, out_valid=last=busy=done=err=0. No done pulse for the aborted sweep.

## Timing
- All outputs registered except last and out_valid, which decode registered state/indices only (no input-to-output combinational path).
- **Start latency:** start accepted at edge N → first beat valid in cycle N+1.
- **Throughput:** one beat per cycle while out_ready is held high. A 2×3 sweep with out_ready=1 occupies RUN for exactly 6 cycles.
- **done:** asserted in the cycle after the last-beat handshake, for exactly one cycle.
- **Turnaround:** earliest next start acceptance is the cycle after done (IDLE). Minimum start-to-start spacing is rows×cols+2 cycles.
- **Zero-size start:** done/err pulse one cycle after start.

## Structure
- Add to the shared ISA.v defines:
  - `LEN_COUNTER_DATA (existing).
  - State encodings `SEQ_IDLE=2'd0, `SEQ_RUN=2'd1, `SEQ_DONE=2'd2.
- Sub-module index_stage (instantiated twice, row and col):
  - Inputs: clk, rst, clr, inc, max.
  - Outputs: idx and wrap (= inc & idx==max−1).
  - Register wraps to 0 on wrap.
  - Col inc = handshake; row inc = handshake & col wrap.
- FSM and handshake logic live in loop_sequencer.

## Test plan
- row_max=2, col_max=3, out_ready=1, start pulse → beats (0,0)(0,1)(0,2)(1,0)(1,1)(1,2) on consecutive cycles; last only on (1,2); done one cycle later; busy low the cycle after.
- Same sweep with out_ready toggling 1,0,0,1,… → identical beat sequence; row/col/last stable across stalls; no duplicated or skipped pairs.
- row_max=0, col_max=5, start → no out_valid; done=err=1 one cycle later; back in IDLE.
- start re-asserted during RUN and during DONE, with row_max changed mid-sweep → ignored; original sweep completes unchanged.
- rst asserted after the third beat of a 4×4 sweep → next cycle all outputs 0, IDLE, no done; a fresh start then sweeps from (0,0).
- row_max=col_max=2^W−1 with W=4 → 225 beats, last at (14,14), done once.
